// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter sharing one physical-memory port between the I- and D-cache.
// Ports: clk, rst_n (async active-low); i_pmem_* / d_pmem_* cache-side requests (read, write,
// address, wdata in; resp, rdata out); pmem_* memory side (read, write, address, wdata out;
// resp, rdata in).
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t            state_q, state_d;
    logic              gnt_q, gnt_d, last_q, last_d, rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              i_req, d_req, sel_d;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;
    // D wins when it requests alone, or on a tie when I was served last
    assign sel_d = d_req & (~i_req | ~last_q);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_q == IDLE) begin
            if (i_req | d_req) begin
                state_d = BUSY;
                gnt_d   = sel_d;
                // write takes priority when a port raises both read and write
                wr_d    = sel_d ? d_pmem_write : i_pmem_write;
                rd_d    = sel_d ? d_pmem_read & ~d_pmem_write : i_pmem_read & ~i_pmem_write;
                addr_d  = sel_d ? d_pmem_address : i_pmem_address;
                wdata_d = sel_d ? d_pmem_wdata : i_pmem_wdata;
            end
        end else if (pmem_resp) begin
            state_d = IDLE;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            last_d  = gnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign i_pmem_resp  = (state_q == BUSY) & pmem_resp & ~gnt_q;
    assign d_pmem_resp  = (state_q == BUSY) & pmem_resp & gnt_q;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, physical address width.
REQ-002 Parameter LINE_W, default 256, cache-line width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_pmem_read / i_pmem_write  input  1 each  instruction-cache line read/write request, held until i_pmem_resp.
REQ-006 i_pmem_address  input  ADDR_W  instruction-cache line address.
REQ-007 i_pmem_wdata  input  LINE_W  instruction-cache writeback line.
REQ-008 i_pmem_resp  output  1  completion to instruction cache.
REQ-009 i_pmem_rdata  output  LINE_W  read line to instruction cache.
REQ-010 d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata, d_pmem_resp, d_pmem_rdata: same directions, widths and meanings for the data cache.
REQ-011 pmem_read / pmem_write  output  1 each  request to physical memory.
REQ-012 pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W; pmem_resp  input  1; pmem_rdata  input  LINE_W.

Function
REQ-013 FSM states: IDLE, BUSY; plus grant register gnt (0=I, 1=D) and last-served register last (0=I, 1=D).
REQ-014 Request from a port = its read OR write; if both are asserted, the transaction is a write and the read is ignored.
REQ-015 In IDLE with only one port requesting, that port is granted at the next edge.
REQ-016 In IDLE with both requesting, the port not equal to last is granted (round-robin); after reset last=I, so D wins the first tie.
REQ-017 On grant edge: latch op, address and wdata of the granted port into output registers, set gnt, go to BUSY; pmem_read/pmem_write assert in the first BUSY cycle (one-cycle request-to-pmem latency).
REQ-018 pmem_read, pmem_write, pmem_address, pmem_wdata are registered and remain constant throughout BUSY, independent of requester input changes.
REQ-019 In BUSY, pmem_resp is routed combinationally to the granted port's resp only; the other port's resp stays 0.
REQ-020 i_pmem_rdata and d_pmem_rdata are combinational copies of pmem_rdata at all times.
REQ-021 On the edge ending a BUSY cycle with pmem_resp=1: clear pmem_read/pmem_write, set last=gnt, return to IDLE; pmem_address/pmem_wdata hold their last values.
REQ-022 IDLE lasts at least one cycle between transactions, so a requester that drops its request after resp is never re-granted.
REQ-023 A requester deasserting mid-BUSY does not abort the transaction; it completes and resp is still delivered.
REQ-024 pmem_resp in IDLE is ignored; no resp is generated to either port.
REQ-025 No request is lost: a waiting port is granted no later than the IDLE cycle following completion of the other port's transaction.

Reset
REQ-026 rst_n low asynchronously forces IDLE, gnt=0, last=I, pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0, both resp=0, including mid-BUSY.
REQ-027 First grant is possible in the first cycle with rst_n high.

Verification
REQ-028 I read only, i_pmem_address=0x0000_1000, pmem_resp after 3 BUSY cycles with rdata=0xAA..AA -> pmem_read=1 one cycle after request, address 0x1000, i_pmem_resp=1 for one cycle with rdata 0xAA..AA, d_pmem_resp=0.
REQ-029 After reset, I read 0x100 and D write 0x200 in the same cycle -> D served first (pmem_write, address 0x200), then IDLE one cycle, then I read 0x100.
REQ-030 Both ports requesting continuously for 4 transactions -> grants alternate D, I, D, I.
REQ-031 During BUSY for D write at 0x300, D changes address to 0x400 and wdata -> pmem_address stays 0x300 and pmem_wdata unchanged until pmem_resp.
REQ-032 rst_n driven low in the 2nd BUSY cycle -> pmem_read/pmem_write drop immediately without a clock edge; after release, a pending I request is granted normally.
REQ-033 pmem_resp pulsed while IDLE with no request -> no resp on either port, state remains IDLE.
